// File: rtl/probabilistic_walk_engine.sv
// probabilistic_walk_engine: multi-trial Metropolis walk sequencing an external proposer and unsat evaluator.
module probabilistic_walk_engine #(
    parameter int VAR_INDEX_W    = 2,
    parameter int INT_W          = 8,
    parameter int CLAUSE_INDEX_W = 3,
    parameter int STEPS_W        = 8,
    parameter int RAND_W         = 8
) (
    input  logic                                 in_clock,
    input  logic                                 in_reset,
    input  logic                                 in_start,
    input  logic                                 in_abort,
    input  logic [15:0]                          in_seed,
    input  logic [STEPS_W-1:0]                   in_max_steps,
    input  logic [2:0]                           in_penalty_shift,
    input  logic [2**VAR_INDEX_W-1:0]            in_initial_boolean,
    input  logic [INT_W*2**VAR_INDEX_W-1:0]      in_initial_integer,
    input  logic [CLAUSE_INDEX_W:0]              in_initial_unsat,
    output logic [2**VAR_INDEX_W-1:0]            out_current_boolean,
    output logic [INT_W*2**VAR_INDEX_W-1:0]      out_current_integer,
    output logic                                 out_propose_request,
    input  logic                                 in_propose_valid,
    input  logic [2**VAR_INDEX_W-1:0]            in_proposed_boolean,
    input  logic [INT_W*2**VAR_INDEX_W-1:0]      in_proposed_integer,
    output logic [2**VAR_INDEX_W-1:0]            out_candidate_boolean,
    output logic [INT_W*2**VAR_INDEX_W-1:0]      out_candidate_integer,
    output logic                                 out_eval_request,
    input  logic                                 in_eval_valid,
    input  logic [CLAUSE_INDEX_W:0]              in_eval_unsat,
    output logic [2**VAR_INDEX_W-1:0]            out_best_boolean,
    output logic [INT_W*2**VAR_INDEX_W-1:0]      out_best_integer,
    output logic [CLAUSE_INDEX_W:0]              out_best_unsat,
    output logic [STEPS_W-1:0]                   out_steps_taken,
    output logic [STEPS_W-1:0]                   out_accepted_count,
    output logic                                 out_busy,
    output logic                                 out_done,
    output logic                                 out_solved
);
    localparam int NV = 2**VAR_INDEX_W;
    localparam int IW = INT_W*NV;
    localparam int UW = CLAUSE_INDEX_W+1;
    localparam int SW = UW+3;
    localparam logic [RAND_W:0] THR_FULL = {1'b1, {RAND_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, PROPOSE, EVALUATE, DECIDE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [NV-1:0]     cur_b_q, cur_b_d, cand_b_q, cand_b_d, best_b_q, best_b_d;
    logic [IW-1:0]     cur_i_q, cur_i_d, cand_i_q, cand_i_d, best_i_q, best_i_d;
    logic [UW-1:0]     best_u_q, best_u_d, u_q, u_d, v_q, v_d;
    logic [STEPS_W-1:0] steps_q, steps_d, acc_q, acc_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              solved_q, solved_d;

    logic [UW-1:0]      diff;
    logic [SW-1:0]      s;
    logic [31:0]        s_ext;
    logic [RAND_W:0]    thr;
    logic               accept, last, in_trial;
    logic [15:0]        lfsr_nxt;
    logic [STEPS_W-1:0] steps_inc, acc_inc;

    always_comb begin
        diff      = v_q - u_q;
        s         = SW'(diff) * SW'(in_penalty_shift);
        s_ext     = 32'(s);
        thr       = THR_FULL >> s;
        // full-width product: a large uphill step must reject, never wrap back to "likely"
        accept    = (v_q <= u_q) || ((s_ext < RAND_W) && ({1'b0, lfsr_q[RAND_W-1:0]} < thr));
        lfsr_nxt  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        last      = ({1'b0, steps_q} + (STEPS_W+1)'(1)) == {1'b0, in_max_steps};
        steps_inc = &steps_q ? steps_q : steps_q + STEPS_W'(1);
        acc_inc   = &acc_q ? acc_q : acc_q + STEPS_W'(1);
        in_trial  = (state_q == PROPOSE) || (state_q == EVALUATE) || (state_q == DECIDE);
        state_d   = state_q;
        cur_b_d   = cur_b_q;
        cur_i_d   = cur_i_q;
        cand_b_d  = cand_b_q;
        cand_i_d  = cand_i_q;
        best_b_d  = best_b_q;
        best_i_d  = best_i_q;
        best_u_d  = best_u_q;
        u_d       = u_q;
        v_d       = v_q;
        steps_d   = steps_q;
        acc_d     = acc_q;
        lfsr_d    = lfsr_q;
        solved_d  = solved_q;
        if (in_abort && in_trial) begin
            state_d = FINISH;
        end else begin
            case (state_q)
                IDLE: if (in_start) begin
                    cur_b_d  = in_initial_boolean;
                    cur_i_d  = in_initial_integer;
                    best_b_d = in_initial_boolean;
                    best_i_d = in_initial_integer;
                    u_d      = in_initial_unsat;
                    best_u_d = in_initial_unsat;
                    solved_d = in_initial_unsat == '0;
                    steps_d  = '0;
                    acc_d    = '0;
                    lfsr_d   = in_seed == '0 ? 16'h0001 : in_seed;
                    state_d  = (in_initial_unsat == '0 || in_max_steps == '0) ? FINISH : PROPOSE;
                end
                PROPOSE: if (in_propose_valid) begin
                    cand_b_d = in_proposed_boolean;
                    cand_i_d = in_proposed_integer;
                    state_d  = EVALUATE;
                end
                EVALUATE: if (in_eval_valid) begin
                    v_d     = in_eval_unsat;
                    state_d = DECIDE;
                end
                DECIDE: begin
                    lfsr_d  = lfsr_nxt;
                    steps_d = steps_inc;
                    if (accept) begin
                        cur_b_d = cand_b_q;
                        cur_i_d = cand_i_q;
                        u_d     = v_q;
                        acc_d   = acc_inc;
                        if (v_q < best_u_q) begin
                            best_b_d = cand_b_q;
                            best_i_d = cand_i_q;
                            best_u_d = v_q;
                            solved_d = v_q == '0;
                        end
                    end
                    state_d = ((accept && v_q == '0) || last) ? FINISH : PROPOSE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q  <= IDLE;
            cur_b_q  <= '0;
            cur_i_q  <= '0;
            cand_b_q <= '0;
            cand_i_q <= '0;
            best_b_q <= '0;
            best_i_q <= '0;
            best_u_q <= '0;
            u_q      <= '0;
            v_q      <= '0;
            steps_q  <= '0;
            acc_q    <= '0;
            lfsr_q   <= 16'h0001;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_b_q  <= cur_b_d;
            cur_i_q  <= cur_i_d;
            cand_b_q <= cand_b_d;
            cand_i_q <= cand_i_d;
            best_b_q <= best_b_d;
            best_i_q <= best_i_d;
            best_u_q <= best_u_d;
            u_q      <= u_d;
            v_q      <= v_d;
            steps_q  <= steps_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
            solved_q <= solved_d;
        end
    end

    assign out_current_boolean   = cur_b_q;
    assign out_current_integer   = cur_i_q;
    assign out_candidate_boolean = cand_b_q;
    assign out_candidate_integer = cand_i_q;
    assign out_best_boolean      = best_b_q;
    assign out_best_integer      = best_i_q;
    assign out_best_unsat        = best_u_q;
    assign out_steps_taken       = steps_q;
    assign out_accepted_count    = acc_q;
    assign out_propose_request   = state_q == PROPOSE;
    assign out_eval_request      = state_q == EVALUATE;
    assign out_busy              = state_q != IDLE;
    assign out_done              = state_q == FINISH;
    assign out_solved            = solved_q;
endmodule

// File: doc/probabilistic_walk_engine.md
# probabilistic_walk_engine

Multi-step successor to the single-move probabilistic search datapath. Runs up to `in_max_steps` Metropolis-style trials per start and sequences an external proposer and an external unsatisfied-clause evaluator through valid/request handshakes. Each trial accepts or rejects using a tunable penalty shift and an internal LFSR, and the engine tracks the best assignment seen. It sits between the top-level solver FSM and the Propose / ComputeGain units, and exits early when all clauses are satisfied.

## Interface

Parameters:
- VAR_INDEX_W, 2: variable index width; there are 2**VAR_INDEX_W boolean variables and 2**VAR_INDEX_W integer variables.
- INT_W, 8: bit width of each integer variable.
- CLAUSE_INDEX_W, 3: unsat counts are CLAUSE_INDEX_W+1 bits wide (UW).
- STEPS_W, 8: width of the step and accept counters.
- RAND_W, 8: number of LFSR bits used for acceptance. Legal range is 1..16.

Ports:
- in_clock, in, 1, the single clock.
- in_reset, in, 1, asynchronous, active-low.
- in_start, in, 1, start pulse. Sampled only in IDLE.
- in_abort, in, 1, ends the run from any busy state.
- in_seed, in, 16, LFSR seed, loaded at start.
- in_max_steps, in, STEPS_W, trial budget.
- in_penalty_shift, in, 3, probability halvings per extra unsatisfied clause.
- in_initial_boolean, in, 2**VAR_INDEX_W, starting boolean assignment.
- in_initial_integer, in, INT_W*2**VAR_INDEX_W, starting integer assignment.
- in_initial_unsat, in, UW, unsat count of the initial assignment.
- out_current_boolean / out_current_integer, out, as the initial ports, current assignment. Drives the proposer.
- out_propose_request, out, 1, request to the proposer.
- in_propose_valid, in, 1, proposer response strobe.
- in_proposed_boolean / in_proposed_integer, in, as the initial ports, proposal data.
- out_candidate_boolean / out_candidate_integer, out, registered proposal. Drives the evaluator.
- out_eval_request, out, 1, request to the evaluator.
- in_eval_valid, in, 1, evaluator response strobe.
- in_eval_unsat, in, UW, unsat count of the candidate.
- out_best_boolean / out_best_integer / out_best_unsat, out, best assignment seen and its unsat count.
- out_steps_taken, out, STEPS_W, trials decided this run.
- out_accepted_count, out, STEPS_W, trials accepted this run.
- out_busy, out, 1, high in every non-IDLE state.
- out_done, out, 1, one-cycle pulse at the end of a run.
- out_solved, out, 1, high when out_best_unsat==0. Valid when out_done is high.

## Operation

- Reset state: every output and register is 0 and the FSM is in IDLE. The LFSR is reset to 16'h0001.
- FSM states are IDLE, PROPOSE, EVALUATE, DECIDE and FINISH.
- IDLE, on in_start:
  - Load current and best from the initial ports, and set u and best_unsat to in_initial_unsat.
  - Clear both counters.
  - Load the LFSR with in_seed, or 16'h0001 if in_seed==0.
  - If in_initial_unsat==0 or in_max_steps==0, go to FINISH. Otherwise go to PROPOSE.
- PROPOSE: out_propose_request is held high. When in_propose_valid is seen, capture the proposal into candidate and go to EVALUATE.
- EVALUATE: out_eval_request is held high. When in_eval_valid is seen, capture v=in_eval_unsat and go to DECIDE.
- DECIDE (one cycle):
  - Let r = LFSR[RAND_W-1:0], the pre-advance value.
  - Accept if v<=u.
  - Otherwise compute s=(v-u)*in_penalty_shift at full width, with no truncation. If s>=RAND_W, reject. If not, accept iff r < (2**RAND_W >> s), compared at RAND_W+1 bits. So s==0 always accepts.
  - The LFSR advances exactly once per DECIDE: a Fibonacci shift-left with the new LSB = l[15]^l[13]^l[12]^l[10].
  - steps increments on every DECIDE.
  - On accept: current<=candidate, u<=v, and accepted increments. If v<best_unsat (strict), best<=candidate and best_unsat<=v.
  - Next state is FINISH if (accept and v==0) or if steps+1==in_max_steps. Otherwise it is PROPOSE.
- FINISH: out_done=1 for one cycle, then IDLE. Outputs hold their values until the next start.
- in_abort in PROPOSE, EVALUATE or DECIDE moves to FINISH on the next edge with no state update. Abort wins over a coincident valid or decision.
- Ignored inputs:
  - A valid strobe outside its own state.
  - in_start while busy.
  - in_abort in IDLE or FINISH.
- Counters saturate at 2**STEPS_W-1.

## Timing

- Start sampled at edge k puts the FSM in PROPOSE from cycle k+1.
- Minimum trial is 3 cycles (PROPOSE, EVALUATE, DECIDE), which needs zero-wait valid strobes.
- A request may be answered in the same cycle it is asserted. Requests drop the cycle after valid is captured.
- out_candidate_* is stable for the whole of EVALUATE.
- out_done rises one cycle after the final DECIDE, or one cycle after an early-exit start or an abort.
- Asserting in_reset mid-run returns the block to IDLE immediately, with all outputs at 0 and no out_done pulse.

## Test plan

- Downhill walk: initial unsat=3, evaluator returns 2, then 1, then 0, max_steps=10 -> all accepted; steps=3, accepted=3, best_unsat=0, out_solved=1, done pulse.
- Uphill rejection: u=1, evaluator always returns 4, shift=3 (s=9>=8), max_steps=5 -> accepted=0, steps=5, current unchanged, best_unsat=1.
- Random walk: shift=0 and evaluator always returns u+2 -> every trial accepted; best is unchanged because improvement must be strict.
- LFSR acceptance: seed=16'h0001, RAND_W=8, v-u=1, shift=1 (threshold 128) -> per-trial accept/reject decisions match a reference LFSR model over 50 trials.
- Early exit: start with in_initial_unsat=0 -> out_done exactly 1 cycle after start with steps=0; separately, max_steps=0 gives the same result.
- Abort and reset: in_abort in the same cycle as in_eval_valid -> no counter or assignment change, done next cycle. in_reset low in EVALUATE -> IDLE immediately, all outputs 0, no done pulse.
